// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling and valid/ack byte handshake
module uart_receiver #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;
    logic                   rx_s;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Next-state logic: synchroniser shift, frame FSM, and handshake flags.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], RxD};
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        frame_err_d = frame_err_q;

        // Ack is applied first so a same-cycle commit sees the consumed byte.
        rx_valid_d  = rx_valid_q & ~rx_ack;
        overrun_d   = overrun_q & ~rx_ack;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end else begin
                        // Start bit did not hold to mid-bit: treat as noise.
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        if (rx_valid_d) begin
                            overrun_d = 1'b1;
                        end
                        rx_data_d   = shift_q;
                        rx_valid_d  = 1'b1;
                        frame_err_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                // Hold off until the line returns high so a held-low line cannot re-trigger.
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            sync_q      <= '1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized and directed bench for uart_receiver against a frame-level model
module tb_uart_receiver;

    localparam int CPB = 16;
    localparam int FRAME_CYCLES = 10 * CPB;

    logic       clk;
    logic       reset;
    logic       RxD;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks;
    int errors;

    // Frame-level model of the user-visible outputs.
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ferr;
    logic       exp_ov;

    uart_receiver #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .RxD      (RxD),
        .rx_ack   (rx_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".rx_data"},   32'(rx_data),   32'(exp_data));
        check_eq({tag, ".rx_valid"},  32'(rx_valid),  32'(exp_valid));
        check_eq({tag, ".frame_err"}, 32'(frame_err), 32'(exp_ferr));
        check_eq({tag, ".overrun"},   32'(overrun),   32'(exp_ov));
    endtask

    task automatic model_reset();
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        exp_ov    = 1'b0;
    endtask

    // A received frame as seen by the consumer: good stop commits, bad stop only flags.
    task automatic model_frame(input logic [7:0] b, input logic stop_bit, input bit acked);
        if (acked) begin
            exp_valid = 1'b0;
            exp_ov    = 1'b0;
        end
        if (stop_bit) begin
            exp_ov    = exp_ov | exp_valid;
            exp_valid = 1'b1;
            exp_data  = b;
            exp_ferr  = 1'b0;
        end else begin
            exp_ferr = 1'b1;
        end
    endtask

    task automatic model_ack();
        exp_valid = 1'b0;
        exp_ov    = 1'b0;
    endtask

    task automatic idle_high(input int n);
        repeat (n) begin
            @(negedge clk);
            RxD = 1'b1;
        end
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    // Drive one 8N1 frame, one line change per negedge. The stop-bit commit lands on the
    // posedge between negedges 154 and 155 (2 sync + 1 detect + CPB/2 + 9*CPB).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit ack_at_commit,
                              input bit check_lat, input int abort_at);
        for (int n = 0; n < FRAME_CYCLES; n++) begin
            int idx;
            @(negedge clk);
            if (check_lat && n == 154) check_eq("lat_before", 32'(rx_valid), 32'd0);
            if (check_lat && n == 155) check_eq("lat_after", 32'(rx_valid), 32'd1);
            if (n == abort_at) begin
                #1 reset = 1'b0;
                #1;
                check_eq("rst_mid.rx_data",   32'(rx_data),   32'd0);
                check_eq("rst_mid.rx_valid",  32'(rx_valid),  32'd0);
                check_eq("rst_mid.frame_err", 32'(frame_err), 32'd0);
                check_eq("rst_mid.overrun",   32'(overrun),   32'd0);
                check_eq("rst_mid.busy",      32'(busy),      32'd0);
                RxD = 1'b1;
                return;
            end
            idx = n / CPB;
            if (idx == 0)      RxD = 1'b0;
            else if (idx == 9) RxD = stop_bit;
            else               RxD = b[idx-1];
            if (ack_at_commit && n == 154) rx_ack = 1'b1;
            if (ack_at_commit && n == 155) rx_ack = 1'b0;
        end
    endtask

    initial begin
        int busy_cnt;
        logic [7:0] rb;
        logic       rstop;
        bit         racked;

        checks = 0;
        errors = 0;
        RxD    = 1'b1;
        rx_ack = 1'b0;
        reset  = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check_outputs("reset");
        check_eq("reset.busy", 32'(busy), 32'd0);
        reset = 1'b1;
        idle_high(5);

        // Single byte with commit timing.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1);
        model_frame(8'hA5, 1'b1, 1'b0);
        check_outputs("single");
        ack_pulse();
        model_ack();
        check_outputs("single_ack");
        check_eq("single.busy", 32'(busy), 32'd0);

        // Glitch on the line shorter than half a bit.
        busy_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            RxD = (n < 4) ? 1'b0 : 1'b1;
        end
        check_eq("glitch.busy_window", 32'(busy_cnt >= 1 && busy_cnt <= 10), 32'd1);
        check_eq("glitch.busy_end", 32'(busy), 32'd0);
        check_outputs("glitch");

        // Framing error followed by a held-low line.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
        repeat (40) begin
            @(negedge clk);
            RxD = 1'b0;
        end
        model_frame(8'h3C, 1'b0, 1'b0);
        check_outputs("ferr");
        check_eq("ferr.busy_held", 32'(busy), 32'd1);
        idle_high(6);
        check_eq("ferr.busy_release", 32'(busy), 32'd0);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, -1);
        model_frame(8'h81, 1'b1, 1'b0);
        check_outputs("ferr_recover");
        ack_pulse();
        model_ack();

        // Overrun: two frames back-to-back without ack.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, -1);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, -1);
        model_frame(8'h22, 1'b1, 1'b0);
        check_outputs("overrun");
        ack_pulse();
        model_ack();
        check_outputs("overrun_ack");

        // Ack on the exact cycle the next byte commits.
        send_frame(8'h44, 1'b1, 1'b0, 1'b0, -1);
        model_frame(8'h44, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b1, 1'b0, -1);
        model_frame(8'h55, 1'b1, 1'b1);
        check_outputs("collision");

        // Asynchronous reset in data bit 3 of 0xF0.
        send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 4 * CPB + CPB / 2);
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle_high(5);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0, -1);
        model_frame(8'h0F, 1'b1, 1'b0);
        check_outputs("after_reset");

        // Randomized frames, stop bits, acks and gaps.
        for (int i = 0; i < 14; i++) begin
            rb     = 8'($urandom_range(0, 255));
            rstop  = ($urandom_range(0, 3) != 0);
            racked = ($urandom_range(0, 1) == 1);
            if (racked) begin
                ack_pulse();
                model_ack();
            end
            send_frame(rb, rstop, 1'b0, 1'b0, -1);
            model_frame(rb, rstop, 1'b0);
            if (!rstop) begin
                repeat ($urandom_range(0, 20)) begin
                    @(negedge clk);
                    RxD = 1'b0;
                end
                idle_high(4 + $urandom_range(0, 10));
            end else begin
                idle_high($urandom_range(0, 6));
            end
            check_outputs($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
